// File: rtl/key_draw_scheduler_pkg.sv
// Shared types and default geometry for the piano-key redraw scheduler.
package key_draw_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, FLUSH} kds_state_e;

    localparam int NUM_KEYS_DEF = 7;
    localparam int KEY_W_DEF    = 16;
    localparam int KEY_H_DEF    = 32;
    localparam int X0_DEF       = 24;
    localparam int PITCH_DEF    = 16;
    localparam int Y0_DEF       = 42;

    localparam int COL_N = $clog2(KEY_W_DEF);
    localparam int ROW_N = $clog2(KEY_H_DEF);

endpackage

// File: rtl/key_draw_scheduler_if.sv
// Sprite-ROM read port and VGA adapter write port owned by the scheduler.
interface key_draw_scheduler_if #(
    parameter int ADDR_W = key_draw_pkg::COL_N + key_draw_pkg::ROW_N
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_sel;
    logic [2:0]        rom_data;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_color;
    logic              plot;

    modport master (
        output rom_addr, rom_sel, vga_x, vga_y, vga_color, plot,
        input  rom_data
    );

    modport slave (
        input  rom_addr, rom_sel, vga_x, vga_y, vga_color, plot,
        output rom_data
    );
endinterface

// File: rtl/key_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 7,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/key_draw_scheduler.sv
// Shares the VGA write port among NUM_KEYS key sprites; redraws a key whenever it changes.
// Build option KDS_TRANSPARENT_EN: black ROM pixels suppress plot so the background survives.
module key_draw_scheduler
    import key_draw_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int KEY_W    = KEY_W_DEF,
    parameter int KEY_H    = KEY_H_DEF,
    parameter int X0       = X0_DEF,
    parameter int PITCH    = PITCH_DEF,
    parameter int Y0       = Y0_DEF
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [NUM_KEYS-1:0]   key_state,
    input  logic                  redraw_all,
    key_draw_scheduler_if.master  bus,
    output logic                  busy,
    output logic [2:0]            cur_key
);
    localparam int COL_W = $clog2(KEY_W);
    localparam int ROW_W = $clog2(KEY_H);
    localparam int AW    = COL_W + ROW_W;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    if (X0 + (NUM_KEYS - 1) * PITCH + KEY_W - 1 > 159) begin : g_x_range
        $error("key_draw_scheduler: rightmost key exceeds x=159");
    end
    if (Y0 + KEY_H - 1 > 119) begin : g_y_range
        $error("key_draw_scheduler: key bottom exceeds y=119");
    end

    kds_state_e          state_q, state_d;
    logic [NUM_KEYS-1:0] key_state_q, pending_q, pending_d, set_req, clr_req;
    logic [NUM_KEYS-1:0] gnt;
    logic [2:0]          gnt_idx, ptr_q, ptr_d, cur_key_q, cur_key_d;
    logic                gnt_any, snap_q, snap_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                rom_sel_q, rom_sel_d, plot_q, plot_d, busy_q, busy_d;
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;

    rr_arbiter #(.N(NUM_KEYS), .IW(3)) u_arb (
        .req (pending_q),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_key_d = cur_key_q;
        snap_d    = snap_q;
        addr_d    = addr_q;
        rom_sel_d = rom_sel_q;
        clr_req   = '0;
        set_req   = (key_state ^ key_state_q) | {NUM_KEYS{redraw_all}};
        case (state_q)
            IDLE: if (gnt_any) begin
                clr_req   = gnt;
                cur_key_d = gnt_idx;
                snap_d    = key_state[gnt_idx];
                ptr_d     = gnt_idx;
                state_d   = LOAD;
            end
            LOAD: begin
                addr_d    = '0;
                rom_sel_d = snap_q;
                state_d   = SCAN;
            end
            SCAN: begin
                // {row,col} is a plain binary count because both dimensions are powers of two
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = FLUSH;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a change landing on its own grant cycle re-queues the key
        pending_d = (pending_q & ~clr_req) | set_req;
        // pixel coordinates follow the address by one cycle to line up with rom_data
        plot_d = (state_q == SCAN);
        x_d    = 8'(X0 + int'(cur_key_q) * PITCH + int'(addr_q[COL_W-1:0]));
        y_d    = 7'(Y0 + int'(addr_q[AW-1:COL_W]));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            key_state_q <= key_state;
            pending_q   <= '1;
            ptr_q       <= 3'(NUM_KEYS - 1);
            cur_key_q   <= '0;
            snap_q      <= 1'b0;
            addr_q      <= '0;
            rom_sel_q   <= 1'b0;
            plot_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_state_q <= key_state;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            cur_key_q   <= cur_key_d;
            snap_q      <= snap_d;
            addr_q      <= addr_d;
            rom_sel_q   <= rom_sel_d;
            plot_q      <= plot_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.rom_sel   = rom_sel_q;
    assign bus.vga_x     = x_q;
    assign bus.vga_y     = y_q;
    assign bus.vga_color = plot_q ? bus.rom_data : 3'd0;
`ifdef KDS_TRANSPARENT_EN
    assign bus.plot      = plot_q & (|bus.rom_data);
`else
    assign bus.plot      = plot_q;
`endif
    assign busy          = busy_q;
    assign cur_key       = cur_key_q;
endmodule

// File: tb/tb_key_draw_scheduler.sv
// Scoreboard bench: a per-draw pixel model queues expected plots; a monitor pops and compares.
module tb_key_draw_scheduler;
    localparam int N  = 7;
    localparam int KW = 16;
    localparam int KH = 32;
    localparam int DRAW_CYC = 1 + KW * KH + 1;
`ifdef KDS_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif
    localparam int PIXK = TRANSP ? (KW * KH / 2) : (KW * KH);

    logic         Clock = 1'b0;
    logic         Resetn = 1'b0;
    logic [N-1:0] key_state = '0;
    logic         redraw_all = 1'b0;
    logic         busy;
    logic [2:0]   cur_key;

    key_draw_scheduler_if #(.ADDR_W(9)) bus ();

    key_draw_scheduler dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .key_state  (key_state),
        .redraw_all (redraw_all),
        .bus        (bus),
        .busy       (busy),
        .cur_key    (cur_key)
    );

    always #10 Clock = ~Clock;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // sprite ROM stand-in: black at even columns, colour otherwise depends on sel and row parity
    function automatic logic [2:0] rom_pix(input logic sel, input int row, input int col);
        if (col % 2 == 0) return 3'd0;
        return {sel, 1'(row % 2), 1'b1};
    endfunction

    always @(posedge Clock)
        bus.rom_data <= rom_pix(bus.rom_sel, int'(bus.rom_addr[8:4]), int'(bus.rom_addr[3:0]));

    // ---------------- reference model ----------------
    typedef struct { int c; int x; int y; int col; } px_t;
    px_t          expq[$];
    int           cyc = 0;
    bit           mpend[N];
    int           mptr = N - 1;
    int           free_at = 0;
    logic [N-1:0] mprev = '0;
    int           last_grant = -100000;
    int           last_key = 0;

    always @(posedge Clock) begin
        bit found;
        int k;
        logic s;
        logic [2:0] p;
        if (!Resetn) begin
            expq.delete();
            for (int i = 0; i < N; i++) mpend[i] = 1'b1;
            mptr       = N - 1;
            free_at    = cyc + 1;
            mprev      = key_state;
            last_grant = -100000;
            last_key   = 0;
        end else begin
            found = 1'b0;
            if (cyc >= free_at) begin
                for (int i = 1; i <= N; i++) begin
                    k = (mptr + i) % N;
                    if (!found && mpend[k]) begin
                        found = 1'b1;
                        mpend[k] = 1'b0;
                        mptr = k;
                        s = key_state[k];
                        for (int r = 0; r < KH; r++)
                            for (int c = 0; c < KW; c++) begin
                                p = rom_pix(s, r, c);
                                if (!TRANSP || p != 3'd0)
                                    expq.push_back('{cyc + 3 + r * KW + c, 24 + 16 * k + c, 42 + r, int'(p)});
                            end
                        free_at    = cyc + DRAW_CYC + 1;
                        last_grant = cyc;
                        last_key   = k;
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (key_state[i] != mprev[i] || redraw_all) mpend[i] = 1'b1;
            mprev = key_state;
        end
        cyc++;
    end

    function automatic bit model_idle();
        bit any;
        any = 1'b0;
        for (int i = 0; i < N; i++) any |= mpend[i];
        return !any && expq.size() == 0 && cyc > last_grant + DRAW_CYC;
    endfunction

    // ---------------- monitor ----------------
    int plot_cnt = 0;

    always @(negedge Clock) begin
        px_t e;
        bit  exp_busy;
        if (cyc >= 1) begin
            exp_busy = (cyc > last_grant) && (cyc <= last_grant + DRAW_CYC);
            chk("busy", int'(busy), int'(exp_busy));
            if (exp_busy) chk("cur_key", int'(cur_key), last_key);
            while (expq.size() > 0 && expq[0].c < cyc) begin
                e = expq.pop_front();
                chk("missed_plot_cycle", cyc, e.c);
            end
            if (bus.plot) begin
                plot_cnt++;
                if (expq.size() == 0) begin
                    chk("unexpected_plot_x", int'(bus.vga_x), -1);
                end else begin
                    e = expq.pop_front();
                    chk("plot_cycle", cyc, e.c);
                    chk("plot_x", int'(bus.vga_x), e.x);
                    chk("plot_y", int'(bus.vga_y), e.y);
                    chk("plot_color", int'(bus.vga_color), e.col);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge Clock);
        while (!model_idle() && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, n, 0);
        repeat (2) @(negedge Clock);
    endtask

    task automatic wait_grant(input int g0, input int budget);
        int n = 0;
        while (last_grant == g0 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (n >= budget) chk("grant_timeout", n, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_plot"},    int'(bus.plot), 0);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_x"},       int'(bus.vga_x), 0);
        chk({tag, "_y"},       int'(bus.vga_y), 0);
        chk({tag, "_color"},   int'(bus.vga_color), 0);
        chk({tag, "_addr"},    int'(bus.rom_addr), 0);
        chk({tag, "_sel"},     int'(bus.rom_sel), 0);
        chk({tag, "_cur_key"}, int'(cur_key), 0);
    endtask

    initial begin
        int g0;
        logic [N-1:0] m;

        // reset with all keys released, then full redraw 0..6
        repeat (3) @(negedge Clock);
        chk_zero_outputs("reset");
        plot_cnt = 0;
        Resetn = 1'b1;
        wait_idle("initial_redraw", 5000);
        chk("initial_redraw_plots", plot_cnt, N * PIXK);

        // single key press
        plot_cnt = 0;
        key_state[3] = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        chk("key3_busy", int'(busy), 1);
        wait_idle("key3", 2000);
        chk("key3_plots", plot_cnt, PIXK);

        // simultaneous changes, pointer sits at 3
        plot_cnt = 0;
        key_state[1] = 1'b1;
        key_state[5] = 1'b1;
        wait_idle("dual", 3000);
        chk("dual_plots", plot_cnt, 2 * PIXK);

        // key 2 toggles twice, second toggle lands mid-scan
        plot_cnt = 0;
        g0 = last_grant;
        key_state[2] = 1'b1;
        wait_grant(g0, 20);
        repeat (100) @(negedge Clock);
        key_state[2] = 1'b0;
        wait_idle("rescan", 3000);
        chk("rescan_plots", plot_cnt, 2 * PIXK);

        // reset at scan cycle 200 of key 4
        g0 = last_grant;
        key_state[4] = 1'b1;
        wait_grant(g0, 20);
        while (cyc < last_grant + 202) @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        chk_zero_outputs("midscan_reset");
        plot_cnt = 0;
        Resetn = 1'b1;
        wait_idle("post_reset", 5000);
        chk("post_reset_plots", plot_cnt, N * PIXK);

        // randomized key activity and redraw_all pulses
        for (int it = 0; it < 12; it++) begin
            m = N'($urandom) & N'($urandom);
            key_state = key_state ^ m;
            if ($urandom_range(0, 5) == 0) redraw_all = 1'b1;
            @(negedge Clock);
            redraw_all = 1'b0;
            repeat ($urandom_range(1, 700)) @(negedge Clock);
        end
        wait_idle("random", 50000);
        chk("final_queue_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule

// File: doc/key_draw_scheduler.md
Name: key_draw_scheduler

Overview:
- Owns the single vga_adapter write port and shares it among NUM_KEYS piano-key sprites.
- Detects key on/off changes and queues redraw requests, one per key.
- Grants requests round-robin, then scans the granted key's sprite ROM pixel by pixel, driving x, y, colour and plot.
- Replaces free-running per-key counters and the one-hot output mux; sits between keyboard/audio state and the VGA adapter.

Parameters:
- NUM_KEYS, 7, number of keys sharing the port.
- KEY_W, 16, sprite width in pixels (power of 2).
- KEY_H, 32, sprite height in pixels (power of 2).
- X0, 24, x of key 0 left edge.
- PITCH, 16, x spacing between keys.
- Y0, 42, top row of all keys.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous, active-low reset.
- key_state  in  NUM_KEYS  1 = key pressed.
- redraw_all  in  1  single-cycle pulse; requests a redraw of every key.
- rom_addr  out  log2(KEY_H)+log2(KEY_W)  {row,col} sprite address, default 9 bits.
- rom_sel  out  1  selects sprite ROM: 1 = key_on, 0 = key_off.
- rom_data  in  3  ROM pixel; valid one cycle after rom_addr.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_color  out  3  pixel colour.
- plot  out  1  write strobe to adapter.
- busy  out  1  high while not IDLE.
- cur_key  out  3  index of the key being drawn.

Behaviour:
- Reset (Resetn=0 at a Clock edge):
  - FSM goes to IDLE.
  - plot=0, busy=0, vga_x=0, vga_y=0, vga_color=0, rom_addr=0, rom_sel=0, cur_key=0.
  - key_state_q is loaded with key_state.
  - pending is set to all ones, so every key is drawn after reset.
  - Round-robin pointer is set to NUM_KEYS-1, so key 0 is granted first.
  - Reset mid-scan aborts immediately; partial sprites are overwritten by the forced full redraw.
- Request set: pending[i] is set when key_state[i] != key_state_q[i], or when redraw_all=1. key_state_q is updated every cycle.
- Request clear: pending[i] is cleared at grant. If a set and a clear land in the same cycle, the set wins, so a change during a scan queues one more redraw.
- IDLE:
  - If pending != 0, grant the first set bit searching upward from pointer+1 (mod NUM_KEYS).
  - Latch cur_key, latch snap_state = key_state[cur_key], set the pointer to cur_key, then go to LOAD.
- LOAD (1 cycle): col=0, row=0, rom_sel=snap_state; go to SCAN.
- SCAN:
  - Each cycle drive rom_addr={row,col}; col increments and wraps at KEY_W-1, then row increments.
  - After the address {KEY_H-1,KEY_W-1} is issued, go to FLUSH.
- Output pipeline: one stage matching ROM latency.
  - vga_x = X0 + cur_key*PITCH + col_d, truncated to 8 bits.
  - vga_y = Y0 + row_d, truncated to 7 bits.
  - vga_color = rom_data; plot = addr_valid_d.
- FLUSH (1 cycle): plots the last pixel, then returns to IDLE. A new grant may happen on the next IDLE cycle.
- Timing:
  - Grant to first plot: 2 cycles.
  - Per key: 1 LOAD + KEY_W*KEY_H SCAN + 1 FLUSH = 514 cycles, with exactly 512 plot pulses.
  - plot is never high in IDLE or LOAD.
- Key state sampling: snap_state is fixed for the whole scan; key_state changes during a scan do not alter colours mid-sprite.
- Synthesis checks:
  - X0+(NUM_KEYS-1)*PITCH+KEY_W-1 must be ≤ 159.
  - Y0+KEY_H-1 must be ≤ 119.

Optional Feature:
- Macro KDS_TRANSPARENT_EN.
- Defined: pixels with rom_data==3'b000 produce plot=0 (transparent), so the background is kept. Cycle count is unchanged.
- Undefined: every scanned pixel is plotted, including black.

Decomposition:
- Package key_draw_pkg holds:
  - the state enum IDLE/LOAD/SCAN/FLUSH;
  - the default geometry constants;
  - the width helpers (COL_N=log2 KEY_W, ROW_N=log2 KEY_H).
- Sub-module rr_arbiter: NUM_KEYS request vector plus pointer in, one-hot grant and index out, combinational. It is instantiated once.

Test Plan:
- Reset release with key_state=0 → keys 0..6 drawn in order, 7×514 cycles, 3584 plots. Key 0 first pixel at (24,42), key 6 last pixel at (135,73). rom_sel=0 throughout.
- Idle, toggle key_state[3] 0→1 → busy within 1 cycle; 512 plots with x in 72..87 and y in 42..73; rom_sel=1; pending returns to 0.
- Keys 1 and 5 change in the same cycle, pointer=3 → key 5 drawn first, then key 1.
- key_state[2] toggles again during key 2's scan → the current scan completes unchanged, then key 2 is redrawn once more with the new state.
- Resetn low at scan cycle 200 → outputs zero next cycle; after release, a full redraw starts at key 0.
- KDS_TRANSPARENT_EN defined with the ROM returning 0 at even col → 256 plots per key and still 514 cycles per key.
